// File: rtl/tia_biphase_decoder.sv
// tia_biphase_decoder: locks onto a 4-step {phi1,phi2,bqb} biphase sequence and flags violations.
// Optional saturating error counter enabled by macro TIA_BIPHASE_ERRCNT_EN.
module tia_biphase_decoder #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W = 8
) (
  input  logic clk,
  input  logic r,
  input  logic phi1,
  input  logic phi2,
  input  logic bqb,
  output logic locked,
  output logic [1:0] phase,
  output logic p1_stb,
  output logic p2_stb,
`ifdef TIA_BIPHASE_ERRCNT_EN
  output logic [ERR_W-1:0] err_cnt,
`endif
  output logic err
);
  typedef enum logic [1:0] {HUNT, ACQ, LOCK} state_t;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  state_t state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [1:0] exp_q, exp_d, idx, phase_d;
  logic [2:0] s;
  logic legal, hit, zero, locked_d, err_d;
  logic locked_q, p1_q, p2_q, err_q;
  logic [1:0] phase_q;
  assign s = {phi1, phi2, bqb};
  assign legal = s == 3'b101 || s == 3'b001 || s == 3'b010 || s == 3'b000;
  assign idx = s == 3'b101 ? 2'd0 : s == 3'b001 ? 2'd1 : s == 3'b010 ? 2'd2 : 2'd3;
  assign hit = legal && idx == exp_q;
  assign zero = legal && idx == 2'd0;
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    exp_d = exp_q;
    err_d = 1'b0;
    case (state_q)
      HUNT: if (zero) begin
        run_d = 4'd1;
        exp_d = 2'd1;
        state_d = LC == 4'd1 ? LOCK : ACQ;
      end
      ACQ: if (hit) begin
        run_d = run_q < LC ? run_q + 4'd1 : run_q;
        exp_d = exp_q + 2'd1;
        state_d = run_q + 4'd1 >= LC ? LOCK : ACQ;
      end else begin
        run_d = zero ? 4'd1 : 4'd0;
        exp_d = zero ? 2'd1 : 2'd0;
        state_d = zero ? ACQ : HUNT;
      end
      LOCK: if (hit) begin
        exp_d = exp_q + 2'd1;
      end else begin
        err_d = 1'b1;
        run_d = zero ? 4'd1 : 4'd0;
        exp_d = zero ? 2'd1 : 2'd0;
        state_d = zero ? ACQ : HUNT;
      end
      default: begin
        state_d = HUNT;
        run_d = 4'd0;
        exp_d = 2'd0;
      end
    endcase
    // Every path into LOCK consumes an in-sequence sample, so idx is the decoded phase.
    locked_d = state_d == LOCK;
    phase_d = locked_d ? idx : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= HUNT;
      run_q <= 4'd0;
      exp_q <= 2'd0;
      locked_q <= 1'b0;
      phase_q <= 2'd0;
      p1_q <= 1'b0;
      p2_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      exp_q <= exp_d;
      locked_q <= locked_d;
      phase_q <= phase_d;
      p1_q <= locked_d && idx == 2'd0;
      p2_q <= locked_d && idx == 2'd2;
      err_q <= err_d;
    end
  end
`ifdef TIA_BIPHASE_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (r) err_cnt_q <= '0;
    else if (err_d && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
  end
  assign err_cnt = err_cnt_q;
`endif
  assign locked = locked_q;
  assign phase = phase_q;
  assign p1_stb = p1_q;
  assign p2_stb = p2_q;
  assign err = err_q;
endmodule

// File: doc/tia_biphase_decoder.md
TIA_BIPHASE_DECODER -- requirements
Module: tia_biphase_decoder

Interface
REQ-001 The block SHALL have parameter LOCK_COUNT, default 4, the number of consecutive legal, in-sequence samples needed to declare lock (legal range 1..15).
REQ-002 The block SHALL have parameter ERR_W, default 8, the width of the error counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 r  input  1  reset, synchronous, active-high.
REQ-005 phi1  input  1  biphase phase-1 pulse under test.
REQ-006 phi2  input  1  biphase phase-2 pulse under test.
REQ-007 bqb  input  1  biphase half-period indicator under test.
REQ-008 locked  output  1  high while the decoder tracks a valid biphase sequence.
REQ-009 phase  output  2  decoded phase index; valid only while locked is high.
REQ-010 p1_stb  output  1  one-cycle strobe on each decoded phase 0 (phi1 pulse) while locked.
REQ-011 p2_stb  output  1  one-cycle strobe on each decoded phase 2 (phi2 pulse) while locked.
REQ-012 err  output  1  one-cycle pulse on a sequence violation detected while locked.
REQ-013 err_cnt  output  ERR_W  saturating count of err pulses; present only with TIA_BIPHASE_ERRCNT_EN.

Function
REQ-014 The block SHALL sample {phi1,phi2,bqb} on every rising clk edge and classify each sample as follows.
- 1,0,1: phase 0.
- 0,0,1: phase 1.
- 0,1,0: phase 2.
- 0,0,0: phase 3.
- Any other pattern: illegal.
REQ-015 The block SHALL treat the legal sequence as phase 0->1->2->3->0, one step per clk; the full period is 4 clks.
REQ-016 The state machine SHALL have three states: HUNT, ACQ and LOCK.
REQ-017 HUNT: on a phase-0 sample, go to ACQ with run count = 1 and expected = 1; otherwise stay in HUNT.
REQ-018 ACQ: a sample equal to expected SHALL increment the run count and advance expected modulo 4.
REQ-019 ACQ: when the run count reaches LOCK_COUNT, go to LOCK.
REQ-020 ACQ: an illegal or out-of-sequence sample SHALL return to HUNT with no err pulse.
- Exception: a phase-0 sample in ACQ restarts ACQ with run count = 1.
REQ-021 With LOCK_COUNT = 1, a phase-0 sample in HUNT SHALL go directly to LOCK.
REQ-022 LOCK: a sample equal to expected SHALL advance expected modulo 4 and keep locked.
REQ-023 LOCK: an illegal or out-of-sequence sample SHALL pulse err for 1 clk, deassert locked and go to HUNT.
- Exception: if that sample is phase 0, go to ACQ with run count = 1.
REQ-024 All outputs SHALL be registered and reflect the sample taken one edge earlier (latency 1 clk).
REQ-025 The phase output SHALL equal the index of the most recent in-sequence sample while locked, and SHALL read 0 otherwise.
REQ-026 p1_stb and p2_stb SHALL assert only when locked will be high in the same cycle, i.e. on in-sequence samples in LOCK and on the sample that completes acquisition.
REQ-027 p1_stb and p2_stb SHALL never both be high, and each SHALL occur exactly once per 4-clk period in steady lock.
REQ-028 The run counter SHALL be 4 bits wide and SHALL NOT wrap: it stops at LOCK_COUNT.

Reset
REQ-029 When r is high at a rising clk edge, the block SHALL enter HUNT with run count 0 and expected 0.
REQ-030 Reset SHALL drive locked, phase, p1_stb, p2_stb and err to 0, and err_cnt to 0 when present.
REQ-031 Reset SHALL take priority over any sample taken on the same edge, including mid-acquisition and mid-lock.
REQ-032 The block SHALL ignore the sample taken on the reset edge; decoding starts from the first edge with r low.

Configuration
REQ-033 With macro TIA_BIPHASE_ERRCNT_EN defined, err_cnt SHALL exist and increment by 1 on each err pulse, saturating at 2^ERR_W-1.
REQ-034 With TIA_BIPHASE_ERRCNT_EN defined, err_cnt SHALL be cleared only by r, never by lock loss.
REQ-035 Without TIA_BIPHASE_ERRCNT_EN, the err_cnt port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Reset high 2 clks, then a clean 4-clk biphase stream starting at phase 0 -> locked rises the cycle after the 4th sample; p1_stb and p2_stb pulse 2 clks apart, each repeating every 4 clks.
REQ-037 In lock, force {phi1,phi2,bqb} = 1,1,0 for one clk -> err = 1 for 1 clk, locked = 0, err_cnt = 1 (macro on); after 4 clean samples, locked = 1 again.
REQ-038 In ACQ after 2 good samples, skip phase 2 (send phase 3) -> state HUNT, err stays 0, locked stays 0.
REQ-039 Assert r for one clk while locked -> next cycle: locked = 0, all outputs 0, err_cnt = 0.
REQ-040 Macro on, ERR_W = 2: inject 5 lock-loss errors -> err_cnt saturates at 3.
REQ-041 Stream starting at phase 2 with LOCK_COUNT = 1 -> no lock until the first phase-0 sample; locked rises the cycle after it and p1_stb pulses in that same cycle.
